// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential imem reads with miss tolerance, a DEPTH-entry
// {inst, pc} FIFO toward decode, and redirect-driven flush with in-flight squash.
module fetch_queue #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] BOOT  = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic [AW-1:0]              imem_addr,
    output logic                       imem_oe,
    input  logic [31:0]                imem_rdata,
    input  logic                       imem_ready,
    output logic                       out_valid,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StWaitDrop} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          inflight, drop, resp, miss, push_credit, issue, push, pop;
    logic [CW:0]   need;

    assign inflight    = (state_q != StIdle);
    assign drop        = (state_q == StWaitDrop);
    assign resp        = inflight && imem_ready;
    assign miss        = inflight && !imem_ready;
    assign push_credit = resp && !drop;

    // Credit check counts the word landing this cycle but not a concurrent pop.
    assign need  = {1'b0, count_q} + (CW + 1)'(push_credit);
    assign issue = rst_n && !redirect && (!inflight || resp) && !miss &&
                   (need < (CW + 1)'(DEPTH));

    assign push = push_credit && !redirect;
    assign pop  = out_valid && out_ready && !redirect;

    assign imem_oe   = issue;
    assign imem_addr = miss ? req_pc_q[AW-1:0] : fetch_pc_q[AW-1:0];
    assign out_valid = (count_q != '0);
    assign out_inst  = inst_mem[rd_ptr_q];
    assign out_pc    = pc_mem[rd_ptr_q];
    assign level     = count_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StWait;
            end
            StWait: begin
                if (redirect) begin
                    state_d = imem_ready ? StIdle : StWaitDrop;
                end else if (imem_ready) begin
                    state_d = issue ? StWait : StIdle;
                end
            end
            StWaitDrop: begin
                if (imem_ready) state_d = issue ? StWait : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~32'd3;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= BOOT;
            req_pc_q   <= BOOT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= imem_rdata;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RV32I pipeline. Issues sequential instruction reads to the single-ported instruction memory and tolerates that memory's one-cycle latency and ready-based misses. Buffers returned words with their PCs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake. A redirect from the execute stage, for a taken branch, jump, ECALL or MRET, flushes the queue and squashes any in-flight read.

## Interface
- AW, 16: instruction-memory byte-address width; imem_addr = fetch_pc[AW-1:0].
- DEPTH, 4: FIFO entries; power of two, ≥2.
- BOOT, 32'h00000000: fetch PC after reset.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (treated as 0).
- imem_addr  out  AW  read address.
- imem_oe  out  1  read request this cycle.
- imem_rdata  in  32  read data for the outstanding request, valid when imem_ready=1 in any cycle after the request.
- imem_ready  in  1  low = outstanding read not yet complete (miss).
- out_valid  out  1  FIFO head valid.
- out_inst  out  32  instruction at head.
- out_pc  out  32  PC of out_inst.
- out_ready  in  1  decode accepts head (inverse of decode stall).
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Registers:
  - fetch_pc (32): next address to request.
  - inflight (1): a request is pending.
  - drop (1): discard the pending response.
  - FIFO storage of {inst, pc}, with read/write pointers and count.
- States, derived from {inflight, drop}:
  - IDLE: inflight=0.
  - WAIT: inflight=1, drop=0.
  - WAIT_DROP: inflight=1, drop=1.
- resp = inflight && imem_ready. A response completes the pending request.
- Issue condition: imem_oe = !redirect && (!inflight || resp) && !drop_blocking && (count + (resp && !drop ? 1 : 0)) < DEPTH.
  - drop_blocking = inflight && !imem_ready.
  - On issue: fetch_pc += 4, inflight<=1, and the PC of the request is latched for tagging.
- Miss: while inflight && !imem_ready, imem_oe=0 and imem_addr holds the pending address. No new request issues until the response arrives.
- Push: resp && !drop && !redirect writes {imem_rdata, tagged pc} at the tail.
- Pop: out_valid && out_ready && !redirect advances the head.
- Push and pop in the same cycle leave count unchanged. Full: no push can occur, because issue is credit-limited.
- Redirect, which has priority over push, pop and issue:
  - count<=0 and pointers reset.
  - fetch_pc<=redirect_pc & ~3.
  - If a request is pending and not completing this cycle, drop<=1 (WAIT→WAIT_DROP). If the pending request completes this cycle, its data is discarded and inflight<=0.
  - WAIT_DROP→IDLE on resp, with the data discarded. Issue from the new PC is allowed in that same cycle.
- Back-to-back redirects: the last one wins; drop stays set until the pending response arrives.
- Arithmetic: fetch_pc wraps modulo 2^32. imem_addr is the low AW bits and wraps silently.

## Timing
- Reset (rst_n=0, asynchronous), values hold while low:
  - out_valid=0, level=0, imem_oe=0.
  - fetch_pc=BOOT, inflight=0, drop=0.
  - out_inst and out_pc are don't-care.
- First cycle after rst_n rises: imem_oe=1, imem_addr=BOOT[AW-1:0].
- Latency with no misses:
  - Request in cycle t, data in t+1, out_valid at t+2.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Redirect asserted in cycle t:
  - out_valid=0 and level=0 in t+1.
  - Redirect-target request in t+1, or on the drop-response cycle if a miss was pending.
  - First redirected instruction visible at t+3 at the earliest.
- Reset asserted mid-miss: all state clears immediately; the memory's late response is ignored because inflight=0.

## Test plan
- Reset release with BOOT=0, imem_ready=1, out_ready=1 -> imem_addr 0,4,8,… on consecutive cycles; out_pc 0 appears 2 cycles after the first request; then one instruction per cycle, in order.
- out_ready=0 for 10 cycles -> level reaches DEPTH=4 and stays there; imem_oe drops to 0 with no overflow. After out_ready=1, out_pc continues 0,4,8,12,16 with no gap and no duplicate.
- imem_ready=0 for 3 cycles after the request to 0x8 -> imem_addr held at 0x8 and imem_oe=0 during the miss; inst 0x8 is pushed exactly once.
- Redirect to 0x100 while FIFO holds 3 entries and a request is completing -> next cycle level=0 and out_valid=0; the completing word is discarded; next request is 0x100; first out_pc is 0x100.
- Redirect to 0x40 during a pending miss, with imem_ready low 2 more cycles -> response discarded (WAIT_DROP); 0x40 issued in the response cycle; no stale PC ever appears on out_pc.
- rst_n pulsed low mid-stream with FIFO full -> out_valid and level go to 0 asynchronously; after release, fetch restarts at BOOT.
